// File: rtl/gfx_mem_pkg.sv
// Shared constants for the graphics video-memory arbiter: channel indices and FSM encoding.
package gfx_mem_pkg;

    localparam int NUM_CH = 4;

    localparam logic [1:0] CH_BG    = 2'd0;
    localparam logic [1:0] CH_SPR   = 2'd1;
    localparam logic [1:0] CH_COP   = 2'd2;
    localparam logic [1:0] CH_SPARE = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational 4-way round-robin select: the first requester after 'last' (mod 4) wins.
module rr_priority_picker
    import gfx_mem_pkg::*;
(
    input  logic [3:0] request,
    input  logic [1:0] last,
    output logic [1:0] winner,
    output logic       any
);

    logic [1:0] idx;

    // Walk from farthest (last itself) to nearest (last+1) so the nearest requester overrides.
    always_comb begin
        winner = last;
        any    = 1'b0;
        idx    = last;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = last + 2'(i);
            if (request[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gfx_memory_arbiter.sv
// Round-robin arbiter for four graphics read masters onto one single-ported 16-bit SPRAM,
// with burst lock so a streaming master keeps the port for up to BURST_MAX reads.
module gfx_memory_arbiter
    import gfx_mem_pkg::*;
#(
    parameter int BURST_MAX = 16,
    parameter int ADDR_BITS = 16
) (
    input  logic                 CLK,
    input  logic                 RSTb,
    input  logic [ADDR_BITS-1:0] ch0_address,
    input  logic                 ch0_rvalid,
    output logic                 ch0_rready,
    input  logic [ADDR_BITS-1:0] ch1_address,
    input  logic                 ch1_rvalid,
    output logic                 ch1_rready,
    input  logic [ADDR_BITS-1:0] ch2_address,
    input  logic                 ch2_rvalid,
    output logic                 ch2_rready,
    input  logic [ADDR_BITS-1:0] ch3_address,
    input  logic                 ch3_rvalid,
    output logic                 ch3_rready,
    output logic [15:0]          memory_data,
    output logic [ADDR_BITS-1:0] mem_address,
    output logic                 mem_rd,
    input  logic [15:0]          mem_data,
    output logic                 dbg_state
);

    // Channel protocol: a master holds chN_rvalid high with a valid address for as long as it
    // wants reads. chN_rready is not an acceptance; it is a one-cycle data strobe meaning
    // memory_data holds the word for the address that was issued one cycle earlier. A master
    // that drops rvalid after its last rready receives one extra strobe and must ignore it.

    localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);

    arb_state_t           state;
    logic [1:0]           grant;
    logic [1:0]           last_served;
    logic [1:0]           pending_ch;
    logic [7:0]           burst_count;
    logic                 pending;
    logic [3:0]           rvalid_vec;
    logic [ADDR_BITS-1:0] grant_addr;
    logic [1:0]           winner;
    logic                 any_req;
    logic                 issue;

    assign rvalid_vec = {ch3_rvalid, ch2_rvalid, ch1_rvalid, ch0_rvalid};

    rr_priority_picker u_picker (
        .request (rvalid_vec),
        .last    (last_served),
        .winner  (winner),
        .any     (any_req)
    );

    always_comb begin
        grant_addr = ch0_address;
        case (grant)
            CH_BG:    grant_addr = ch0_address;
            CH_SPR:   grant_addr = ch1_address;
            CH_COP:   grant_addr = ch2_address;
            CH_SPARE: grant_addr = ch3_address;
            default:  grant_addr = ch0_address;
        endcase
    end

    assign issue       = (state == GRANT) && rvalid_vec[grant];
    assign mem_rd      = issue;
    assign mem_address = (state == GRANT) ? grant_addr : '0;
    assign memory_data = mem_data;
    assign dbg_state   = state;

    // Data return runs off pending alone, so a burst's final word still lands after IDLE.
    assign ch0_rready = pending && (pending_ch == CH_BG);
    assign ch1_rready = pending && (pending_ch == CH_SPR);
    assign ch2_rready = pending && (pending_ch == CH_COP);
    assign ch3_rready = pending && (pending_ch == CH_SPARE);

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state       <= IDLE;
            grant       <= 2'd0;
            last_served <= 2'd3;
            burst_count <= 8'd0;
            pending     <= 1'b0;
            pending_ch  <= 2'd0;
        end else begin
            pending <= issue;
            if (issue) begin
                pending_ch <= grant;
            end
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant       <= winner;
                        burst_count <= 8'd0;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (!rvalid_vec[grant] || (burst_count == BURST_LAST)) begin
                        state       <= IDLE;
                        last_served <= grant;
                    end else begin
                        burst_count <= burst_count + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
